// File: rtl/tm_core_param.sv
// Parametrised Turing-machine core: private transition table and multi-bit tape,
// free-running or single-step execution, 3 cycles per step (FETCH/LOOKUP/EXEC).
module tm_core_param #(
    parameter int unsigned SYM_W     = 2,
    parameter int unsigned STATE_W   = 4,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned MAX_STEPS = 1023,
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W    = $clog2(MAX_STEPS + 1),
    localparam int unsigned IW       = STATE_W + SYM_W,
    localparam int unsigned E        = 1 + STATE_W + 2 + SYM_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [IW-1:0]      cfg_addr,
    input  logic [E-1:0]       cfg_data,
    input  logic               tape_we,
    input  logic [AW-1:0]      tape_addr,
    input  logic [SYM_W-1:0]   tape_wdata,
    output logic [SYM_W-1:0]   tape_rdata,
    input  logic               start,
    input  logic [AW-1:0]      head_init,
    input  logic               step_mode,
    input  logic               step,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [1:0]         done_reason,
    output logic [STATE_W-1:0] cur_state,
    output logic [AW-1:0]      head_pos,
    output logic [CNT_W-1:0]   step_count
);

    typedef enum logic [2:0] {StIdle, StFetch, StLookup, StExec, StPause, StDone} st_e;

    localparam logic [1:0] RsnHalt  = 2'd0;
    localparam logic [1:0] RsnEdge  = 2'd1;
    localparam logic [1:0] RsnLimit = 2'd2;
    localparam logic [1:0] RsnAbort = 2'd3;

    st_e                st_q, st_d;
    logic [SYM_W-1:0]   tape_q [DEPTH];
    logic [E-1:0]       tbl_q [2**IW];
    logic [SYM_W-1:0]   sym_q;
    logic [E-1:0]       ent_q;
    logic [STATE_W-1:0] state_q, state_d;
    logic [AW-1:0]      head_q, head_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [1:0]         reason_q, reason_d;
    logic [SYM_W-1:0]   rdata_q;

    logic               ent_halt;
    logic [STATE_W-1:0] ent_next;
    logic [1:0]         ent_move;
    logic [SYM_W-1:0]   ent_wsym;
    logic               is_busy, go_right, go_left, at_edge, addr_ok, head_ok;

    assign {ent_halt, ent_next, ent_move, ent_wsym} = ent_q;

    assign is_busy  = (st_q == StFetch) || (st_q == StLookup) ||
                      (st_q == StExec) || (st_q == StPause);
    assign go_right = (ent_move == 2'b01);
    assign go_left  = (ent_move == 2'b10);
    assign at_edge  = (go_left && head_q == '0) || (go_right && head_q == AW'(DEPTH - 1));
    // Guards only matter when DEPTH is not a power of two.
    assign addr_ok  = 32'(tape_addr) < DEPTH;
    assign head_ok  = 32'(head_q) < DEPTH;
    assign cnt_inc  = (cnt_q == CNT_W'(MAX_STEPS)) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        st_d     = st_q;
        state_d  = state_q;
        head_d   = head_q;
        cnt_d    = cnt_q;
        reason_d = reason_q;
        case (st_q)
            StIdle, StDone: begin
                if (start) begin
                    st_d    = StFetch;
                    head_d  = head_init;
                    state_d = '0;
                    cnt_d   = '0;
                end
            end
            StFetch:  st_d = StLookup;
            StLookup: st_d = StExec;
            StExec: begin
                cnt_d = cnt_inc;
                if (ent_halt) begin
                    st_d     = StDone;
                    reason_d = RsnHalt;
                end else begin
                    state_d = ent_next;
                    if (at_edge) begin
                        st_d     = StDone;
                        reason_d = RsnEdge;
                    end else begin
                        if (go_right) begin
                            head_d = head_q + AW'(1);
                        end else if (go_left) begin
                            head_d = head_q - AW'(1);
                        end
                        if (cnt_inc == CNT_W'(MAX_STEPS)) begin
                            st_d     = StDone;
                            reason_d = RsnLimit;
                        end else begin
                            st_d = step_mode ? StPause : StFetch;
                        end
                    end
                end
            end
            StPause: begin
                if (step || !step_mode) begin
                    st_d = StFetch;
                end
            end
            default: st_d = StIdle;
        endcase
        // Abort only redirects the FSM; an EXEC step in the same cycle still commits.
        if (is_busy && abort) begin
            st_d     = StDone;
            reason_d = RsnAbort;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q     <= StIdle;
            state_q  <= '0;
            head_q   <= '0;
            cnt_q    <= '0;
            reason_q <= RsnHalt;
            sym_q    <= '0;
            ent_q    <= '0;
        end else begin
            st_q     <= st_d;
            state_q  <= state_d;
            head_q   <= head_d;
            cnt_q    <= cnt_d;
            reason_q <= reason_d;
            if (st_q == StFetch) begin
                sym_q <= head_ok ? tape_q[head_q] : '0;
            end
            if (st_q == StLookup) begin
                ent_q <= tbl_q[{state_q, sym_q}];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tape_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            rdata_q <= addr_ok ? tape_q[tape_addr] : '0;
            if (st_q == StExec) begin
                if (head_ok) begin
                    tape_q[head_q] <= ent_wsym;
                end
            end else if (!is_busy && tape_we && addr_ok) begin
                tape_q[tape_addr] <= tape_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 2**IW; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (!is_busy && cfg_we) begin
            tbl_q[cfg_addr] <= cfg_data;
        end
    end

    assign tape_rdata  = rdata_q;
    assign busy        = is_busy;
    assign done        = (st_q == StDone);
    assign done_reason = reason_q;
    assign cur_state   = state_q;
    assign head_pos    = head_q;
    assign step_count  = cnt_q;

endmodule

// File: tb/tb_tm_core_param.sv
// Self-checking bench for tm_core_param: directed scenarios plus randomized machines,
// all checked against an interpreter-style reference model of the Turing machine.
module tb_tm_core_param;

    localparam int SYM_W     = 2;
    localparam int STATE_W   = 4;
    localparam int DEPTH     = 16;
    localparam int MAX_STEPS = 8;
    localparam int AW        = 4;
    localparam int CNT_W     = 4;
    localparam int IW        = STATE_W + SYM_W;
    localparam int E         = 1 + STATE_W + 2 + SYM_W;
    localparam int NSYM      = 1 << SYM_W;
    localparam int NENT      = 1 << IW;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [IW-1:0]      cfg_addr = '0;
    logic [E-1:0]       cfg_data = '0;
    logic               tape_we = 1'b0;
    logic [AW-1:0]      tape_addr = '0;
    logic [SYM_W-1:0]   tape_wdata = '0;
    logic [SYM_W-1:0]   tape_rdata;
    logic               start = 1'b0;
    logic [AW-1:0]      head_init = '0;
    logic               step_mode = 1'b0;
    logic               step = 1'b0;
    logic               abort = 1'b0;
    logic               busy, done;
    logic [1:0]         done_reason;
    logic [STATE_W-1:0] cur_state;
    logic [AW-1:0]      head_pos;
    logic [CNT_W-1:0]   step_count;

    tm_core_param #(
        .SYM_W    (SYM_W),
        .STATE_W  (STATE_W),
        .DEPTH    (DEPTH),
        .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .tape_we    (tape_we),
        .tape_addr  (tape_addr),
        .tape_wdata (tape_wdata),
        .tape_rdata (tape_rdata),
        .start      (start),
        .head_init  (head_init),
        .step_mode  (step_mode),
        .step       (step),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .done_reason(done_reason),
        .cur_state  (cur_state),
        .head_pos   (head_pos),
        .step_count (step_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_halt [NENT];
    int m_next [NENT];
    int m_move [NENT];
    int m_wsym [NENT];
    int tape_m [DEPTH];
    int e_n, e_head, e_state, e_reason;
    int tr_head  [MAX_STEPS + 1];
    int tr_state [MAX_STEPS + 1];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NENT; i++) begin
            m_halt[i] = 0; m_next[i] = 0; m_move[i] = 0; m_wsym[i] = 0;
        end
        for (int i = 0; i < DEPTH; i++) tape_m[i] = 0;
    endtask

    // Interprets the machine step by step; updates tape_m and the expected results.
    task automatic model_run(input int h0);
        int h, s, idx;
        bit fin;
        h = h0; s = 0; e_n = 0; fin = 0; e_reason = 0;
        while (!fin) begin
            idx = s * NSYM + tape_m[h];
            tape_m[h] = m_wsym[idx];
            e_n++;
            if (m_halt[idx] != 0) begin
                e_reason = 0; fin = 1;
            end else begin
                s = m_next[idx];
                if ((m_move[idx] == 1 && h == DEPTH - 1) || (m_move[idx] == 2 && h == 0)) begin
                    e_reason = 1; fin = 1;
                end else begin
                    if (m_move[idx] == 1) h++;
                    else if (m_move[idx] == 2) h--;
                    if (e_n == MAX_STEPS) begin
                        e_reason = 2; fin = 1;
                    end else begin
                        tr_head[e_n] = h; tr_state[e_n] = s;
                    end
                end
            end
        end
        e_head = h; e_state = s;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic cfg_wr(input int st, input int sy, input int h, input int nx, input int mv,
                          input int ws);
        int idx;
        idx = st * NSYM + sy;
        cfg_addr = IW'(idx);
        cfg_data = {1'(h), STATE_W'(nx), 2'(mv), SYM_W'(ws)};
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        m_halt[idx] = h; m_next[idx] = nx; m_move[idx] = mv; m_wsym[idx] = ws;
    endtask

    task automatic tape_wr(input int a, input int v);
        tape_addr = AW'(a); tape_wdata = SYM_W'(v); tape_we = 1'b1;
        tick();
        tape_we = 1'b0;
        tape_m[a] = v;
    endtask

    task automatic readback(input string nm);
        for (int a = 0; a < DEPTH; a++) begin
            tape_addr = AW'(a);
            tick();
            chk({nm, "_tape"}, int'(tape_rdata), tape_m[a]);
        end
    endtask

    task automatic check_final(input string nm);
        chk({nm, "_done"}, int'(done), 1);
        chk({nm, "_reason"}, int'(done_reason), e_reason);
        chk({nm, "_head"}, int'(head_pos), e_head);
        chk({nm, "_state"}, int'(cur_state), e_state);
        chk({nm, "_count"}, int'(step_count), e_n);
    endtask

    // Free-running run compared cycle by cycle; poke tries writes while busy.
    task automatic do_run(input string nm, input int h0, input bit poke);
        model_run(h0);
        head_init = AW'(h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3 * e_n; k++) begin
            if (poke && k == 2) begin
                tape_addr = AW'((h0 + 1) % DEPTH); tape_wdata = 2'd3; tape_we = 1'b1;
                cfg_addr = IW'(1 * NSYM + 0); cfg_data = {1'b0, 4'd2, 2'b01, 2'd2}; cfg_we = 1'b1;
            end
            tick();
            tape_we = 1'b0; cfg_we = 1'b0;
            chk({nm, "_busy"}, int'(busy), int'(k < 3 * e_n));
            chk({nm, "_done_cyc"}, int'(done), int'(k >= 3 * e_n));
            if (k % 3 == 0 && k < 3 * e_n) begin
                chk({nm, "_step_cnt"}, int'(step_count), k / 3);
                chk({nm, "_step_head"}, int'(head_pos), tr_head[k / 3]);
                chk({nm, "_step_state"}, int'(cur_state), tr_state[k / 3]);
            end
        end
        check_final(nm);
        readback(nm);
    endtask

    task automatic prog_halt2();
        cfg_wr(0, 0, 0, 1, 1, 1);
        cfg_wr(1, 0, 1, 0, 0, 1);
    endtask

    initial begin
        int w;
        bit got;
        model_clear();
        tick();
        // Reset state
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_head", int'(head_pos), 0);
        chk("rst_count", int'(step_count), 0);
        chk("rst_rdata", int'(tape_rdata), 0);
        reset_n = 1'b1;
        tick();

        // Halt after two steps
        prog_halt2();
        do_run("halt2", 5, 0);
        chk("halt2_lit_head", int'(head_pos), 6);
        chk("halt2_lit_count", int'(step_count), 2);
        chk("halt2_lit_reason", int'(done_reason), 0);
        chk("halt2_lit_state", int'(cur_state), 1);
        chk("halt2_lit_t5", tape_m[5], 1);
        chk("halt2_lit_t6", tape_m[6], 1);

        // Left edge
        cfg_wr(0, 0, 0, 0, 2, 1);
        do_run("edge", 2, 0);
        chk("edge_lit_head", int'(head_pos), 0);
        chk("edge_lit_count", int'(step_count), 3);
        chk("edge_lit_reason", int'(done_reason), 1);

        // Same-cycle write and readback returns the old value first
        do_reset();
        tape_wr(4, 1);
        tape_addr = AW'(4); tape_wdata = 2'd2; tape_we = 1'b1;
        tick();
        tape_we = 1'b0;
        chk("wr_rd_old", int'(tape_rdata), 1);
        tick();
        chk("wr_rd_new", int'(tape_rdata), 2);
        tape_m[4] = 2;

        // Step limit
        do_reset();
        cfg_wr(0, 0, 0, 0, 1, 0);
        do_run("limit", 0, 0);
        chk("limit_lit_head", int'(head_pos), 8);
        chk("limit_lit_count", int'(step_count), 8);
        chk("limit_lit_reason", int'(done_reason), 2);

        // Abort during step 4, then restart from a new head_init
        do_reset();
        cfg_wr(0, 0, 0, 0, 1, 0);
        head_init = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", int'(done), 1);
        chk("abort_reason", int'(done_reason), 3);
        chk("abort_cnt_range", int'(step_count == 3 || step_count == 4), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_done_reason", int'(done_reason), 3);
        chk("abort_in_done_busy", int'(busy), 0);
        do_run("rerun", 3, 0);
        chk("rerun_lit_head", int'(head_pos), 11);

        // Reset mid-run
        do_reset();
        cfg_wr(0, 0, 0, 0, 1, 1);
        head_init = '0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_reason", int'(done_reason), 0);
        chk("midrst_state", int'(cur_state), 0);
        chk("midrst_head", int'(head_pos), 0);
        chk("midrst_count", int'(step_count), 0);
        chk("midrst_rdata", int'(tape_rdata), 0);
        tick();
        reset_n = 1'b1;
        model_clear();
        readback("midrst");

        // Step mode
        do_reset();
        prog_halt2();
        model_run(5);
        step_mode = 1'b1; head_init = AW'(5); start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        for (int k = 0; k < 10; k++) begin
            chk("pause_busy", int'(busy), 1);
            chk("pause_head", int'(head_pos), 6);
            chk("pause_count", int'(step_count), 1);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        w = 0; got = 0;
        while (!got && w < 12) begin
            tick();
            w++;
            got = done;
        end
        chk("step_wait_cycles", w, 3);
        check_final("stepmode");
        step_mode = 1'b0;
        readback("stepmode");

        // Busy lockout
        do_reset();
        prog_halt2();
        do_run("lockout", 5, 1);

        // Randomized machines
        for (int it = 0; it < 20; it++) begin
            do_reset();
            for (int s = 0; s < (1 << STATE_W); s++) begin
                for (int y = 0; y < NSYM; y++) begin
                    cfg_wr(s, y, int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                end
            end
            for (int a = 0; a < DEPTH; a++) tape_wr(a, int'($urandom_range(0, 3)));
            do_run("rand", int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
